// File: rtl/axi4_lite_slave_regfile.sv
// AXI4-Lite slave register file.
// Terminates the AW/W/B and AR/R channels of one master onto a bank of
// NUM_REGS read/write registers. The full bank is exported flat on REG_OUT.
// One write and one read may be in flight at once, one per channel.
module axi4_lite_slave_regfile #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_REGS      = 8
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    input  logic [ADDRESS_WIDTH-1:0]       S_AXI_AWADDR,
    input  logic                           S_AXI_AWVALID,
    output logic                           S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                           S_AXI_WVALID,
    output logic                           S_AXI_WREADY,
    output logic [1:0]                     S_AXI_BRESP,
    output logic                           S_AXI_BVALID,
    input  logic                           S_AXI_BREADY,
    input  logic [ADDRESS_WIDTH-1:0]       S_AXI_ARADDR,
    input  logic                           S_AXI_ARVALID,
    output logic                           S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                     S_AXI_RRESP,
    output logic                           S_AXI_RVALID,
    input  logic                           S_AXI_RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] REG_OUT
);

    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W    = $clog2(NUM_REGS);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_LIMIT = ADDRESS_WIDTH'(NUM_REGS * STRB_W);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Merge a new word into an old one, byte lane by byte lane.
    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [STRB_W-1:0]     strb
    );
        logic [DATA_WIDTH-1:0] result;
        result = old_word;
        for (int i = 0; i < STRB_W; i++) begin
            if (strb[i]) begin
                result[i*8 +: 8] = new_word[i*8 +: 8];
            end else begin
                result[i*8 +: 8] = old_word[i*8 +: 8];
            end
        end
        return result;
    endfunction

    logic [DATA_WIDTH-1:0]    r_regs [NUM_REGS];
    logic                     r_aw_held;
    logic                     r_w_held;
    logic [ADDRESS_WIDTH-1:0] r_awaddr;
    logic [DATA_WIDTH-1:0]    r_wdata;
    logic [STRB_W-1:0]        r_wstrb;
    logic                     r_awready;
    logic                     r_wready;
    logic                     r_bvalid;
    logic [1:0]               r_bresp;
    logic                     r_arready;
    logic                     r_rvalid;
    logic [1:0]               r_rresp;
    logic [DATA_WIDTH-1:0]    r_rdata;

    logic                     w_aw_hs;
    logic                     w_w_hs;
    logic                     w_ar_hs;
    logic                     w_commit;
    logic                     w_aw_in_range;
    logic                     w_ar_in_range;
    logic [IDX_W-1:0]         w_aw_idx;
    logic [IDX_W-1:0]         w_ar_idx;

    assign w_aw_hs       = S_AXI_AWVALID && r_awready;
    assign w_w_hs        = S_AXI_WVALID && r_wready;
    assign w_ar_hs       = S_AXI_ARVALID && r_arready;
    // A new write only lands once the previous response has been taken.
    assign w_commit      = r_aw_held && r_w_held && !r_bvalid;
    assign w_aw_idx      = r_awaddr[ADDR_LSB +: IDX_W];
    assign w_ar_idx      = S_AXI_ARADDR[ADDR_LSB +: IDX_W];
    assign w_aw_in_range = (r_awaddr < ADDR_LIMIT);
    assign w_ar_in_range = (S_AXI_ARADDR < ADDR_LIMIT);

    // Write address capture; ready is low while an address is held.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_awready <= 1'b0;
            r_aw_held <= 1'b0;
            r_awaddr  <= {ADDRESS_WIDTH{1'b0}};
        end else if (w_aw_hs) begin
            r_awready <= 1'b0;
            r_aw_held <= 1'b1;
            r_awaddr  <= S_AXI_AWADDR;
        end else if (w_commit) begin
            r_awready <= 1'b1;
            r_aw_held <= 1'b0;
        end else begin
            r_awready <= !r_aw_held;
        end
    end

    // Write data capture; ready is low while data is held.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_wready <= 1'b0;
            r_w_held <= 1'b0;
            r_wdata  <= {DATA_WIDTH{1'b0}};
            r_wstrb  <= {STRB_W{1'b0}};
        end else if (w_w_hs) begin
            r_wready <= 1'b0;
            r_w_held <= 1'b1;
            r_wdata  <= S_AXI_WDATA;
            r_wstrb  <= S_AXI_WSTRB;
        end else if (w_commit) begin
            r_wready <= 1'b1;
            r_w_held <= 1'b0;
        end else begin
            r_wready <= !r_w_held;
        end
    end

    // Register bank update and write response.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                r_regs[k] <= {DATA_WIDTH{1'b0}};
            end
            r_bvalid <= 1'b0;
            r_bresp  <= RESP_OKAY;
        end else if (w_commit) begin
            if (w_aw_in_range) begin
                r_regs[w_aw_idx] <= merge_lanes(r_regs[w_aw_idx], r_wdata, r_wstrb);
            end
            r_bvalid <= 1'b1;
            r_bresp  <= w_aw_in_range ? RESP_OKAY : RESP_SLVERR;
        end else if (r_bvalid && S_AXI_BREADY) begin
            r_bvalid <= 1'b0;
        end
    end

    // Read path: load the decoded register at the AR handshake and hold it.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rresp   <= RESP_OKAY;
            r_rdata   <= {DATA_WIDTH{1'b0}};
        end else if (w_ar_hs) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b1;
            r_rresp   <= w_ar_in_range ? RESP_OKAY : RESP_SLVERR;
            r_rdata   <= w_ar_in_range ? r_regs[w_ar_idx] : {DATA_WIDTH{1'b0}};
        end else if (r_rvalid && S_AXI_RREADY) begin
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
        end else begin
            r_arready <= !r_rvalid;
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg_out
        assign REG_OUT[k*DATA_WIDTH +: DATA_WIDTH] = r_regs[k];
    end

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_wready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RRESP   = r_rresp;
    assign S_AXI_RDATA   = r_rdata;

endmodule

// File: tb/tb_axi4_lite_slave_regfile.sv
// Directed bench for axi4_lite_slave_regfile (4 x 32-bit registers).
// Expected responses are queued when a transaction is driven and popped
// when the DUT presents the matching B or R beat.
module tb_axi4_lite_slave_regfile;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [31:0] S_AXI_AWADDR;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [31:0] S_AXI_ARADDR;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic [127:0] REG_OUT;

    axi4_lite_slave_regfile #(
        .ADDRESS_WIDTH(32),
        .DATA_WIDTH   (32),
        .NUM_REGS     (4)
    ) dut (
        .ACLK         (ACLK),
        .ARESET       (ARESET),
        .S_AXI_AWADDR (S_AXI_AWADDR),
        .S_AXI_AWVALID(S_AXI_AWVALID),
        .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA  (S_AXI_WDATA),
        .S_AXI_WSTRB  (S_AXI_WSTRB),
        .S_AXI_WVALID (S_AXI_WVALID),
        .S_AXI_WREADY (S_AXI_WREADY),
        .S_AXI_BRESP  (S_AXI_BRESP),
        .S_AXI_BVALID (S_AXI_BVALID),
        .S_AXI_BREADY (S_AXI_BREADY),
        .S_AXI_ARADDR (S_AXI_ARADDR),
        .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA  (S_AXI_RDATA),
        .S_AXI_RRESP  (S_AXI_RRESP),
        .S_AXI_RVALID (S_AXI_RVALID),
        .S_AXI_RREADY (S_AXI_RREADY),
        .REG_OUT      (REG_OUT)
    );

    // 100 MHz clock.
    always #5 ACLK = ~ACLK;

    int          n_total = 0;
    int          n_pass  = 0;
    int          n_fail  = 0;
    logic [1:0]  exp_b [$];
    logic [33:0] exp_r [$];
    logic [31:0] model [4];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    function automatic logic [127:0] model_flat();
        return {model[3], model[2], model[1], model[0]};
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] w;
        if (addr < 32'd16) begin
            w = model[addr[3:2]];
            for (int i = 0; i < 4; i++) begin
                if (strb[i]) w[i*8 +: 8] = data[i*8 +: 8];
            end
            model[addr[3:2]] = w;
        end
    endtask

    function automatic logic [1:0] exp_resp(input logic [31:0] addr);
        return (addr < 32'd16) ? 2'b00 : 2'b10;
    endfunction

    // Drive AW and W with independent start delays until both handshake.
    task automatic send_aw_w(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly);
        int   cyc;
        logic aw_done, w_done, aw_hs, w_hs;
        cyc = 0; aw_done = 1'b0; w_done = 1'b0;
        S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
        while (!(aw_done && w_done) && cyc < 40) begin
            S_AXI_AWVALID = !aw_done && (cyc >= aw_dly);
            S_AXI_WVALID  = !w_done && (cyc >= w_dly);
            aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
            w_hs  = S_AXI_WVALID && S_AXI_WREADY;
            tick();
            cyc++;
            if (aw_hs) aw_done = 1'b1;
            if (w_hs)  w_done  = 1'b1;
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        check("aw_w_accepted", {aw_done, w_done}, 2'b11);
    endtask

    task automatic wait_b(output int lat);
        lat = 0;
        while (!S_AXI_BVALID && lat < 20) begin
            tick();
            lat++;
        end
        check("bvalid_seen", S_AXI_BVALID, 1'b1);
    endtask

    task automatic pop_b();
        if (exp_b.size() > 0) check("bresp", S_AXI_BRESP, exp_b.pop_front());
        else check("b_queue_nonempty", exp_b.size(), 1);
    endtask

    task automatic pop_r();
        logic [33:0] e;
        if (exp_r.size() > 0) begin
            e = exp_r.pop_front();
            check("rresp", S_AXI_RRESP, e[33:32]);
            check("rdata", S_AXI_RDATA, e[31:0]);
        end else begin
            check("r_queue_nonempty", exp_r.size(), 1);
        end
    endtask

    task automatic b_accept();
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
        check("bvalid_cleared", S_AXI_BVALID, 1'b0);
    endtask

    // Full write: expected response and register image come from the model.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly);
        int lat;
        exp_b.push_back(exp_resp(addr));
        send_aw_w(addr, data, strb, aw_dly, w_dly);
        wait_b(lat);
        check("write_latency", lat, 1);
        pop_b();
        model_write(addr, data, strb);
        check("reg_out_after_write", REG_OUT, model_flat());
        b_accept();
    endtask

    task automatic do_read(input logic [31:0] addr);
        int   cyc;
        logic hs;
        exp_r.push_back({exp_resp(addr), (addr < 32'd16) ? model[addr[3:2]] : 32'h0000_0000});
        S_AXI_ARADDR  = addr;
        S_AXI_ARVALID = 1'b1;
        S_AXI_RREADY  = 1'b1;
        cyc = 0; hs = 1'b0;
        while (!hs && cyc < 20) begin
            hs = S_AXI_ARREADY;
            tick();
            cyc++;
        end
        S_AXI_ARVALID = 1'b0;
        check("rvalid_after_ar", S_AXI_RVALID, 1'b1);
        pop_r();
        tick();
        S_AXI_RREADY = 1'b0;
        check("rvalid_cleared", S_AXI_RVALID, 1'b0);
    endtask

    initial begin
        int lat;
        ARESET = 1'b1;
        S_AXI_AWADDR = 32'h0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = 32'h0; S_AXI_WSTRB = 4'h0; S_AXI_WVALID = 1'b0;
        S_AXI_BREADY = 1'b0;
        S_AXI_ARADDR = 32'h0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
        for (int i = 0; i < 4; i++) model[i] = 32'h0;

        // Reset state.
        repeat (3) tick();
        check("rst_readies", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
        check("rst_valids", {S_AXI_BVALID, S_AXI_RVALID}, 2'b00);
        check("rst_resps", {S_AXI_BRESP, S_AXI_RRESP}, 4'h0);
        check("rst_rdata", S_AXI_RDATA, 32'h0);
        check("rst_reg_out", REG_OUT, 128'h0);
        ARESET = 1'b0;
        tick();
        check("readies_after_rst", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);

        // Same-cycle AW/W write.
        do_write(32'h8, 32'hDEADBEEF, 4'hF, 0, 0);
        check("reg2_deadbeef", REG_OUT[95:64], 32'hDEADBEEF);

        // Channel order: W first, then AW first.
        do_write(32'h4, 32'hAABBCCDD, 4'hF, 0, 0);
        do_write(32'h4, 32'h11223344, 4'h5, 3, 0);
        check("reg1_w_first", REG_OUT[63:32], 32'hAA22CC44);
        do_write(32'h4, 32'hAABBCCDD, 4'hF, 0, 0);
        do_write(32'h4, 32'h11223344, 4'h5, 0, 3);
        check("reg1_aw_first", REG_OUT[63:32], 32'hAA22CC44);
        do_write(32'h0, 32'hFFFFFFFF, 4'h0, 0, 0);

        // Out of range.
        do_write(32'h10, 32'hFFFFFFFF, 4'hF, 0, 0);
        do_read(32'h10);
        do_read(32'h4);

        // Response backpressure with a second write queued behind it.
        exp_b.push_back(2'b00);
        send_aw_w(32'h0, 32'h0F0F0F0F, 4'hF, 0, 0);
        wait_b(lat);
        model_write(32'h0, 32'h0F0F0F0F, 4'hF);
        exp_b.push_back(2'b00);
        send_aw_w(32'hC, 32'h33333333, 4'hF, 0, 0);
        for (int i = 0; i < 4; i++) begin
            check("bp_bvalid_held", S_AXI_BVALID, 1'b1);
            check("bp_bresp_stable", S_AXI_BRESP, 2'b00);
            check("bp_no_commit", REG_OUT, model_flat());
            tick();
        end
        pop_b();
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
        check("bp_gap_bvalid", S_AXI_BVALID, 1'b0);
        check("bp_gap_no_commit", REG_OUT, model_flat());
        tick();
        check("bp_second_bvalid", S_AXI_BVALID, 1'b1);
        model_write(32'hC, 32'h33333333, 4'hF);
        check("bp_second_commit", REG_OUT, model_flat());
        pop_b();
        b_accept();

        // Read/write collision on reg2.
        do_write(32'h8, 32'h00000001, 4'hF, 0, 0);
        exp_b.push_back(2'b00);
        exp_r.push_back({2'b00, model[2]});
        send_aw_w(32'h8, 32'h00000002, 4'hF, 0, 0);
        check("coll_arready", S_AXI_ARREADY, 1'b1);
        S_AXI_ARADDR = 32'h8;
        S_AXI_ARVALID = 1'b1;
        tick();
        S_AXI_ARVALID = 1'b0;
        model_write(32'h8, 32'h00000002, 4'hF);
        check("coll_bvalid", S_AXI_BVALID, 1'b1);
        check("coll_rvalid", S_AXI_RVALID, 1'b1);
        pop_b();
        pop_r();
        check("coll_reg_out", REG_OUT, model_flat());
        S_AXI_BREADY = 1'b1;
        S_AXI_RREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
        S_AXI_RREADY = 1'b0;
        check("coll_handshakes_done", {S_AXI_BVALID, S_AXI_RVALID}, 2'b00);
        do_read(32'h8);

        // Reset with an address held and no data.
        S_AXI_AWADDR = 32'h0;
        S_AXI_AWVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        check("mid_aw_taken", S_AXI_AWREADY, 1'b0);
        ARESET = 1'b1;
        tick();
        check("mid_rst_awready", S_AXI_AWREADY, 1'b0);
        check("mid_rst_bvalid", S_AXI_BVALID, 1'b0);
        tick();
        tick();
        ARESET = 1'b0;
        for (int i = 0; i < 4; i++) model[i] = 32'h0;
        tick();
        check("mid_awready_back", S_AXI_AWREADY, 1'b1);
        check("mid_reg_out_zero", REG_OUT, 128'h0);
        S_AXI_WDATA = 32'hFFFFFFFF;
        S_AXI_WSTRB = 4'hF;
        S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_WVALID = 1'b0;
        repeat (3) tick();
        check("mid_no_bvalid", S_AXI_BVALID, 1'b0);
        check("mid_no_write", REG_OUT, 128'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
